// File: rtl/alu_pkg.sv
// Shared ALU opcodes, sequencer state encoding and iteration count.
package alu_pkg;

    localparam logic [4:0] OPC_ADD = 5'b00000;
    localparam logic [4:0] OPC_SUB = 5'b00001;
    localparam logic [4:0] OPC_AND = 5'b00010;
    localparam logic [4:0] OPC_OR  = 5'b00011;
    localparam logic [4:0] OPC_SLL = 5'b00100;
    localparam logic [4:0] OPC_SRA = 5'b00101;

    localparam int N_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: add/sub with signed overflow, logic ops, shifts, compare flags.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_ALUopcode,
    input  logic [4:0]  ctrl_shiftamt,
    output logic [31:0] data_result,
    output logic        isNotEqual,
    output logic        isLessThan,
    output logic        overflow
);

    logic        is_sub;
    logic [31:0] b_eff;
    logic [31:0] sum;
    logic [31:0] diff;

    always_comb begin
        is_sub   = (ctrl_ALUopcode == OPC_SUB);
        b_eff    = is_sub ? ~data_operandB : data_operandB;
        sum      = data_operandA + b_eff + {31'd0, is_sub};
        overflow = (data_operandA[31] == b_eff[31]) && (sum[31] != data_operandA[31]);

        // Compare flags always come from A-B, independent of the opcode.
        diff       = data_operandA - data_operandB;
        isNotEqual = (data_operandA != data_operandB);
        isLessThan = diff[31] ^ ((data_operandA[31] != data_operandB[31]) &&
                                 (diff[31] != data_operandA[31]));

        case (ctrl_ALUopcode)
            OPC_ADD, OPC_SUB: data_result = sum;
            OPC_AND:          data_result = data_operandA & data_operandB;
            OPC_OR:           data_result = data_operandA | data_operandB;
            OPC_SLL:          data_result = data_operandA << ctrl_shiftamt;
            OPC_SRA:          data_result = $signed(data_operandA) >>> ctrl_shiftamt;
            default:          data_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_multdiv_seq.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// that routes every add/subtract through one shared alu instance.
module alu_multdiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [4:0] LAST = 5'(N_ITER - 1);

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    // hi/lo double as remainder/quotient in DIV; m holds multiplicand or divisor.
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic             qm1_q, qm1_d;
    logic             neg_q, neg_d, dexc_q, dexc_d, dz_q, dz_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d, rdy_q, rdy_d;

    logic             start_ok, div_zero, booth_use, borrow, sgn;
    logic [WIDTH-1:0] r_sh, q_sh, sum, abs_a, abs_b;
    logic [WIDTH-1:0] alu_a, alu_res;
    logic [4:0]       alu_op;
    logic             alu_ovf, alu_ne_unused, alu_lt_unused;

    alu alu_sh (
        .data_operandA  (alu_a),
        .data_operandB  (m_q),
        .ctrl_ALUopcode (alu_op),
        .ctrl_shiftamt  (5'd0),
        .data_result    (alu_res),
        .isNotEqual     (alu_ne_unused),
        .isLessThan     (alu_lt_unused),
        .overflow       (alu_ovf)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            neg_q   <= 1'b0;
            dexc_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            neg_q   <= neg_d;
            dexc_q  <= dexc_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    // A pending divide-by-zero completion also blocks new starts for its one cycle.
    assign start_ok = (state_q == ST_IDLE) && !dz_q;
    assign div_zero = (data_operandB == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok && ctrl_MULT)
                    state_d = ST_MUL;
                else if (start_ok && ctrl_DIV && !div_zero)
                    state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        r_sh   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        q_sh   = {lo_q[WIDTH-2:0], 1'b0};
        alu_a  = hi_q;
        alu_op = OPC_ADD;
        if (state_q == ST_DIV) begin
            alu_a  = r_sh;
            alu_op = OPC_SUB;
        end else if (state_q == ST_MUL && lo_q[0] && !qm1_q) begin
            alu_op = OPC_SUB;
        end
    end

    always_comb begin
        state_hold: begin
            cnt_d  = cnt_q;
            hi_d   = hi_q;
            lo_d   = lo_q;
            m_d    = m_q;
            qm1_d  = qm1_q;
            neg_d  = neg_q;
            dexc_d = dexc_q;
            dz_d   = 1'b0;
            res_d  = res_q;
            exc_d  = exc_q;
            rdy_d  = 1'b0;
        end
        abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        booth_use = lo_q[0] ^ qm1_q;
        sum       = booth_use ? alu_res : hi_q;
        // Sign from the ALU's true result keeps the Booth partial product exact.
        sgn       = booth_use ? (alu_res[WIDTH-1] ^ alu_ovf) : hi_q[WIDTH-1];
        borrow    = (r_sh[WIDTH-1] != m_q[WIDTH-1]) ? m_q[WIDTH-1] : alu_res[WIDTH-1];

        if (dz_q) begin
            res_d = '0;
            exc_d = 1'b1;
            rdy_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok && ctrl_MULT) begin
                    hi_d  = '0;
                    lo_d  = data_operandB;
                    qm1_d = 1'b0;
                    m_d   = data_operandA;
                    cnt_d = '0;
                end else if (start_ok && ctrl_DIV) begin
                    if (div_zero) begin
                        dz_d = 1'b1;
                    end else begin
                        hi_d   = '0;
                        lo_d   = abs_a;
                        m_d    = abs_b;
                        neg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        dexc_d = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                 (data_operandB == {WIDTH{1'b1}});
                        cnt_d  = '0;
                    end
                end
            end
            ST_MUL: begin
                hi_d  = {sgn, sum[WIDTH-1:1]};
                lo_d  = {sum[0], lo_q[WIDTH-1:1]};
                qm1_d = lo_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d = lo_d;
                    exc_d = (hi_d != {WIDTH{lo_d[WIDTH-1]}});
                    rdy_d = 1'b1;
                end
            end
            ST_DIV: begin
                hi_d  = borrow ? r_sh : alu_res;
                lo_d  = {q_sh[WIDTH-1:1], ~borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d = neg_q ? (~lo_d + 1'b1) : lo_d;
                    exc_d = dexc_q;
                    rdy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy           = (state_q != ST_IDLE);
        data_result    = res_q;
        data_exception = exc_q;
        data_resultRDY = rdy_q;
    end

endmodule

// File: tb/tb_alu_multdiv_seq.sv
// Directed bench for alu_multdiv_seq: hand-computed products/quotients, latency, reset abort, arbitration.
module tb_alu_multdiv_seq;

    logic        clock, reset, ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY, busy;

    int checks = 0;
    int errors = 0;

    alu_multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a start now, then waits for RDY; poke>0 pulses ctrl_DIV (B=0) that many edges in.
    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e,
                          input int exp_lat, input int poke);
        int lat;
        logic seen;
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
        chk({tag, ":rdy_after_start"}, {31'd0, data_resultRDY}, 32'd0);
        chk({tag, ":busy_after_start"}, {31'd0, busy}, {31'd0, exp_lat > 1});
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (poke > 0 && lat == poke) begin
                ctrl_DIV = 1'b1; data_operandB = 32'd0;
            end else if (poke > 0 && lat == poke + 1) begin
                ctrl_DIV = 1'b0;
            end
            seen = data_resultRDY;
        end
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":result"}, data_result, exp_r);
        chk({tag, ":exception"}, {31'd0, data_exception}, {31'd0, exp_e});
        chk({tag, ":busy_at_rdy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rdy_hits;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        #12;
        chk("reset:result", data_result, 32'd0);
        chk("reset:exception", {31'd0, data_exception}, 32'd0);
        chk("reset:rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset:busy", {31'd0, busy}, 32'd0);
        @(negedge clock); reset = 1'b0;

        @(negedge clock);
        run_op("mul_3x-7", 1, 0, 32'd3, 32'hFFFFFFF9, 32'hFFFFFFEB, 0, 32, 0);
        @(posedge clock); #1;
        chk("mul_3x-7:rdy_single_cycle", {31'd0, data_resultRDY}, 32'd0);
        chk("mul_3x-7:result_held", data_result, 32'hFFFFFFEB);

        @(negedge clock);
        run_op("mul_min_x_-1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 32, 0);
        @(negedge clock);
        run_op("mul_2^16_sq", 1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 32, 0);
        @(negedge clock);
        run_op("mul_min_x_1", 1, 0, 32'h80000000, 32'h00000001, 32'h80000000, 0, 32, 0);
        @(negedge clock);
        run_op("div_-100_7", 0, 1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, 32, 0);
        @(negedge clock);
        run_op("div_100_-7", 0, 1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 0, 32, 0);
        @(negedge clock);
        run_op("div_min_1", 0, 1, 32'h80000000, 32'd1, 32'h80000000, 0, 32, 0);
        @(negedge clock);
        run_op("div_min_-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 32, 0);
        @(negedge clock);
        run_op("div_5_0", 0, 1, 32'd5, 32'd0, 32'd0, 1, 1, 0);
        @(negedge clock);
        run_op("div_1000_-9", 0, 1, 32'd1000, 32'hFFFFFFF7, 32'hFFFFFF91, 0, 32, 0);

        // Abort a multiply mid-iteration with an asynchronous reset.
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd5; data_operandB = 32'd9;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("abort:result", data_result, 32'd0);
        chk("abort:exception", {31'd0, data_exception}, 32'd0);
        chk("abort:rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("abort:busy", {31'd0, busy}, 32'd0);
        @(negedge clock); reset = 1'b0;
        rdy_hits = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_hits++;
        end
        chk("abort:no_rdy", 32'(rdy_hits), 32'd0);
        @(negedge clock);
        run_op("mul_6x7_after_reset", 1, 0, 32'd6, 32'd7, 32'd42, 0, 32, 0);

        @(negedge clock);
        run_op("div_ignores_start_while_busy", 0, 1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 0, 32, 5);
        @(negedge clock);
        run_op("mult_wins_over_div", 1, 1, 32'd20, 32'd3, 32'd60, 0, 32, 0);

        @(negedge clock);
        run_op("b2b_first", 1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 32, 0);
        run_op("b2b_second", 0, 1, 32'hFFFFFFCE, 32'd5, 32'hFFFFFFF6, 0, 32, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_multdiv_seq.md
# alu_multdiv_seq

Iterative signed 32-bit multiply/divide sequencer that time-shares one instance of the existing combinational `alu` for all add/subtract work. It sits beside the ALU in the execute stage. The pipeline hands it a MULT or DIV request and receives a result, an exception flag and a one-cycle ready pulse 32 cycles later. All operand registers, shifting and sign fix-up are local; every add/subtract goes through the shared `alu` via opcodes `00000` (add) and `00001` (sub).

## Interface
- `WIDTH`, default 32: datapath width. Only 32 is supported because `alu` is fixed at 32 bits.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ctrl_MULT` in 1: start signed multiply. Sampled only while `busy`=0.
- `ctrl_DIV` in 1: start signed divide. Sampled only while `busy`=0.
- `data_operandA` in 32: multiplicand or dividend, latched at start.
- `data_operandB` in 32: multiplier or divisor, latched at start.
- `data_result` out 32: registered result. Held until the next completion.
- `data_exception` out 1: registered error flag, qualified by `data_resultRDY`.
- `data_resultRDY` out 1: one-cycle completion pulse.
- `busy` out 1: operation in progress. Start requests are ignored while it is high.

## Operation
- States: IDLE, MUL, DIV, plus a 5-bit iteration counter.
- IDLE:
  - `ctrl_MULT`=1 → MUL. It takes priority if both `ctrl_MULT` and `ctrl_DIV` are high.
  - `ctrl_DIV`=1 → DIV, or finish immediately on divide-by-zero.
- MUL, radix-2 Booth:
  - Registers: hi[31:0], lo[31:0] (initialised to B), q₋₁ (initialised to 0), M (initialised to A).
  - Each iteration examines {lo[0], q₋₁}: 01 → ALU add hi+M; 10 → ALU sub hi−M; 00/11 → hi unchanged.
  - Then arithmetic-shift {hi, lo, q₋₁} right by 1.
  - The sign bit shifted into hi[31] is `aluresult[31] ^ alu overflow` when the ALU was used, otherwise hi[31]. This keeps the intermediate exact.
  - After 32 iterations: result = lo. Exception = hi ≠ {32{lo[31]}}.
- DIV, restoring on magnitudes:
  - Load: R=0, Q=|A|, D=|B|. Magnitudes use a local two's-complement negate, not the ALU.
  - Each iteration: shift {R,Q} left 1, then ALU sub R−D.
  - Unsigned borrow = (R[31]≠D[31]) ? D[31] : diff[31].
  - No borrow: R=diff and Q[0]=1. Borrow: R unchanged and Q[0]=0.
  - Final quotient: negate Q if A[31]^B[31]. This truncates toward zero. The remainder is discarded.
  - 0x80000000 / 0xFFFFFFFF: result 0x80000000, exception=1.
  - B=0: no iterations. Result 0, exception=1.
- ALU shared port:
  - `ctrl_shiftamt` is tied to 0.
  - Opcode is sub when (MUL with {lo[0], q₋₁}=10) or DIV; add otherwise.
  - `isNotEqual` and `isLessThan` are unused.

## Timing
- Reset (asynchronous):
  - State → IDLE, counter=0.
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0.
  - Reset mid-operation aborts the operation and no RDY pulse is produced.
- Start accepted at rising edge N: operands are latched and `busy`=1 after N.
- Iterations occur at edges N+1 … N+32.
- At edge N+32:
  - The result and exception registers are written, including sign fix-up.
  - `data_resultRDY`=1 and `busy`=0.
  - State → IDLE.
- `data_resultRDY` clears at edge N+33.
- A new start may be sampled at edge N+33. That is back-to-back issue; RDY still clears.
- Divide-by-zero: result and exception are written at edge N+1, RDY is high for one cycle, and `busy` never rises.
- Operand inputs may change freely after edge N.
- `data_result` is stable from RDY until the next completion.

## Structure
- Shared package/header `alu_pkg`:
  - ALU opcode constants OPC_ADD=5'b00000, OPC_SUB=5'b00001, OPC_AND, OPC_OR, OPC_SLL, OPC_SRA.
  - State encoding for IDLE/MUL/DIV.
  - Iteration count constant N_ITER=32.
- Sub-module: one instance of the existing `alu`, named `alu_sh`.
- No other hierarchy. The negators are small local `~x+1` expressions.

## Test plan
- 3 × −7: `ctrl_MULT` pulse → `data_result`=0xFFFFFFEB, exception 0, RDY exactly 32 edges after the start edge, single-cycle.
- Multiply exceptions:
  - 0x80000000 × 0xFFFFFFFF → result 0x80000000, exception 1.
  - 0x00010000 × 0x00010000 → result 0, exception 1.
  - 0x80000000 × 1 → 0x80000000, exception 0. This case exercises ALU overflow in the Booth path.
- Signed divides:
  - −100 / 7 → 0xFFFFFFF2 (−14), exception 0.
  - 100 / −7 → −14.
  - 0x80000000 / 1 → 0x80000000.
  - 0x80000000 / 0xFFFFFFFF → 0x80000000, exception 1.
- 5 / 0 → result 0, exception 1, RDY one edge after start, `busy` stays 0.
- Reset asserted asynchronously mid-clock during iteration 10 of a multiply → all outputs 0 immediately and no RDY. A following 6 × 7 returns 42.
- Request arbitration:
  - `ctrl_DIV` pulsed while busy → ignored, and the first result is unaffected.
  - `ctrl_MULT` and `ctrl_DIV` asserted together → the multiply is performed.
  - A start issued in the RDY cycle completes 32 edges later.
